// File: rtl/wb_write_queue.sv
// Write-back stage: selects the result, queues up to two register-file writes
// and forwards queued values to EX. Optional retire counter: WB_RETIRE_CNT_EN.
module wb_write_queue #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic              flush,
  input  logic              mem_regwrite,
  input  logic              mem_memtoreg,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_load_data,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0] wb_wdata,
  input  logic              rf_ready,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_count
`endif
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

  logic [1:0]        count_q, count_d;
  logic [ADDR_W-1:0] head_rd_q, head_rd_d;
  logic [ADDR_W-1:0] tail_rd_q, tail_rd_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [DATA_W-1:0] tail_data_q, tail_data_d;
  logic              accept, enq, pop;
  logic [DATA_W-1:0] new_data;

  assign mem_ready = (count_q < TWO);
  assign accept    = mem_valid && mem_ready && !flush;
  assign enq       = accept && mem_regwrite && (mem_rd != ZR);
  assign pop       = (count_q != EMPTY) && rf_ready;
  assign new_data  = mem_memtoreg ? mem_load_data : mem_alu_result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= EMPTY;
      head_rd_q   <= '0;
      head_data_q <= '0;
      tail_rd_q   <= '0;
      tail_data_q <= '0;
    end else begin
      count_q     <= count_d;
      head_rd_q   <= head_rd_d;
      head_data_q <= head_data_d;
      tail_rd_q   <= tail_rd_d;
      tail_data_q <= tail_data_d;
    end
  end

  // Vacated slots are zeroed so the head reads 0 whenever the queue is empty
  always_comb begin
    count_d     = count_q;
    head_rd_d   = head_rd_q;
    head_data_d = head_data_q;
    tail_rd_d   = tail_rd_q;
    tail_data_d = tail_data_q;
    unique case (count_q)
      EMPTY: begin
        if (enq) begin
          count_d     = ONE;
          head_rd_d   = mem_rd;
          head_data_d = new_data;
        end
      end
      ONE: begin
        if (enq && pop) begin
          head_rd_d   = mem_rd;
          head_data_d = new_data;
        end else if (enq) begin
          count_d     = TWO;
          tail_rd_d   = mem_rd;
          tail_data_d = new_data;
        end else if (pop) begin
          count_d     = EMPTY;
          head_rd_d   = '0;
          head_data_d = '0;
        end
      end
      TWO: begin
        if (pop) begin
          count_d     = ONE;
          head_rd_d   = tail_rd_q;
          head_data_d = tail_data_q;
          tail_rd_d   = '0;
          tail_data_d = '0;
        end
      end
      default: begin
        count_d     = EMPTY;
        head_rd_d   = '0;
        head_data_d = '0;
        tail_rd_d   = '0;
        tail_data_d = '0;
      end
    endcase
  end

  always_comb begin
    wb_we    = (count_q != EMPTY);
    wb_waddr = head_rd_q;
    wb_wdata = head_data_q;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_addr != ZR) begin
      if (count_q == TWO && tail_rd_q == fwd_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = tail_data_q;
      end else if (count_q != EMPTY && head_rd_q == fwd_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = head_data_q;
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_count <= '0;
    end else if (accept) begin
      retire_count <= retire_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/wb_write_queue.md
# wb_write_queue

Write-back stage that captures MEM-stage results, selects the write-back value, and queues register-file writes in a 2-entry buffer. It drives the register file's write port directly: `wb_waddr` feeds the write-address decoder tree built from 1:2 decoders, and `wb_we` feeds that tree's enable. It also provides a forwarding lookup so EX can read values that are queued but not yet written.

## Interface
- `DATA_W`, default 64: register data width.
- `ADDR_W`, default 5: register address width.
- `ZERO_REG`, default 31: hard-wired zero register; writes to it are discarded.

Ports:
- `clk` in 1: single clock, rising-edge.
- `reset` in 1: asynchronous, active-high.
- `mem_valid` in 1: MEM stage presents an instruction.
- `mem_ready` out 1: buffer can accept; equals count < 2.
- `flush` in 1: kills the MEM transaction offered this cycle.
- `mem_regwrite` in 1: instruction writes a register.
- `mem_memtoreg` in 1: 1 selects load data, 0 selects ALU result.
- `mem_rd` in ADDR_W: destination register.
- `mem_alu_result` in DATA_W: ALU result.
- `mem_load_data` in DATA_W: load data.
- `wb_we` out 1: head-entry write enable to the decoder-tree enable.
- `wb_waddr` out ADDR_W: head-entry address to the decoder-tree input.
- `wb_wdata` out DATA_W: head-entry data.
- `rf_ready` in 1: register file consumes the head write at this rising edge.
- `fwd_addr` in ADDR_W: EX source register to look up.
- `fwd_hit` out 1: a queued entry matches `fwd_addr`.
- `fwd_data` out DATA_W: data of the matching entry.
- `retire_count` out 32: present only with `WB_RETIRE_CNT_EN`.

## Operation
- Storage is 2 entries {rd, data}, kept in FIFO order as head and tail, plus a 2-bit count (0, 1 or 2).
- States are EMPTY (0), ONE (1) and TWO (2); the state equals count.
- Accept occurs when `mem_valid && mem_ready && !flush`.
- Enqueue occurs when accept is true, `mem_regwrite` is 1 and `mem_rd != ZERO_REG`. Other accepted instructions are consumed without enqueue.
- Enqueued data is `mem_memtoreg ? mem_load_data : mem_alu_result`, selected at capture.
- Pop occurs when count > 0 and `rf_ready` is 1; the head entry is removed.
- State transitions:
  - EMPTY: enqueue goes to ONE; pop is not possible.
  - ONE: enqueue with pop stays in ONE, and the new entry becomes head. Enqueue alone goes to TWO. Pop alone goes to EMPTY.
  - TWO: accept is blocked because `mem_ready` is 0. Pop goes to ONE, and the tail becomes head.
- Outputs:
  - `wb_we` = (count > 0).
  - `wb_waddr` and `wb_wdata` come from the head entry; they are 0 when EMPTY.
- Forwarding is combinational and searches newest first: tail if count = 2, otherwise head.
  - `fwd_hit` = 0 when `fwd_addr == ZERO_REG`.
  - `fwd_data` = 0 when `fwd_hit` = 0.
- `flush` never removes queued entries; they are committed.
- `reset` at any time, including mid-operation, asynchronously forces count = 0, clears all entries, and forces every output to 0. `mem_ready` = 1 after reset.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on `wb_we/wb_waddr/wb_wdata` after edge N if the queue was empty.
- `mem_ready` depends only on registered count. There is no combinational path from `rf_ready` to `mem_ready`.
- `wb_*` outputs are driven straight from registers; there is no combinational input-to-output path.
- `fwd_hit` and `fwd_data` are combinational from `fwd_addr` and the registered entries.
- When `mem_valid` is 1 and `mem_ready` is 0, upstream holds all `mem_*` inputs stable. The block does not latch them.

## Configuration
- `WB_RETIRE_CNT_EN` defined:
  - `retire_count` is a 32-bit register, reset to 0.
  - It increments by 1 on every accept, including non-writing instructions and writes to `ZERO_REG`.
  - It wraps from 0xFFFFFFFF to 0.
- `WB_RETIRE_CNT_EN` undefined: the `retire_count` port and counter logic are absent.

## Test plan
- Reset, then accept rd=3, memtoreg=0, alu=0x1234 with `rf_ready` = 1 → next cycle `wb_we` = 1, `wb_waddr` = 3, `wb_wdata` = 0x1234; after the following edge `wb_we` = 0.
- Hold `rf_ready` = 0 and accept rd=1 (load 0xAA), then rd=2 → `mem_ready` = 0. `fwd_addr` = 2 gives hit with the rd=2 data; `fwd_addr` = 1 gives 0xAA. Raise `rf_ready` → rd=1, then rd=2 drain in order.
- Accept rd=31 with regwrite=1, and separately rd=5 with regwrite=0 → `wb_we` stays 0; `retire_count` increases by 2.
- Accept rd=7 with `flush` = 1 → nothing enqueued and `retire_count` unchanged. Flush while TWO → both entries still drain.
- Assert `reset` mid-cycle with TWO queued → `wb_we`, `fwd_hit` and `retire_count` go to 0 immediately, and `mem_ready` = 1.
- In ONE, accept rd=9 while `rf_ready` = 1 → count stays 1 and the head becomes rd=9.
